// File: rtl/scalar_reg_wr_arbiter.sv
// Round-robin write-port arbiter sharing the integer and FP scalar register file write ports.
// Optional macro SCALAR_ARB_X0_ZERO_EN: integer writes to index 0 are accepted but suppressed.
module scalar_reg_wr_arbiter #(
    parameter int NUM_REQ          = 3,
    parameter int SCALAR_REG_WIDTH = 64,
    parameter int SCALAR_REG_DEPTH = 32,
    localparam int PTR_W           = $clog2(SCALAR_REG_DEPTH)
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                flush,
    input  logic [NUM_REQ-1:0]                  req_valid,
    input  logic [NUM_REQ-1:0]                  req_fp,
    input  logic [NUM_REQ*PTR_W-1:0]            req_ptr,
    input  logic [NUM_REQ*SCALAR_REG_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]                  req_ready,
    output logic                                write,
    output logic [PTR_W-1:0]                    wr_access_ptr,
    output logic [SCALAR_REG_WIDTH-1:0]         write_data,
    output logic                                fwrite,
    output logic [PTR_W-1:0]                    wr_faccess_ptr,
    output logic [SCALAR_REG_WIDTH-1:0]         fwrite_data
);

    localparam int RR_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]          int_match;
    logic [NUM_REQ-1:0]          fp_match;
    logic [PTR_W-1:0]            ptr_arr  [NUM_REQ];
    logic [SCALAR_REG_WIDTH-1:0] data_arr [NUM_REQ];

    logic [RR_W-1:0] rr_int_reg, rr_int_next;
    logic [RR_W-1:0] rr_fp_reg,  rr_fp_next;
    logic [RR_W:0]   int_pick, fp_pick;
    logic [RR_W-1:0] int_idx, fp_idx;
    logic            int_grant, fp_grant;
    logic            int_wr_en;

    logic                        write_reg;
    logic [PTR_W-1:0]            wr_ptr_reg;
    logic [SCALAR_REG_WIDTH-1:0] wr_data_reg;
    logic                        fwrite_reg;
    logic [PTR_W-1:0]            fwr_ptr_reg;
    logic [SCALAR_REG_WIDTH-1:0] fwr_data_reg;

    assign int_match = req_valid & ~req_fp;
    assign fp_match  = req_valid &  req_fp;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
            assign ptr_arr[gi]  = req_ptr[gi*PTR_W +: PTR_W];
            assign data_arr[gi] = req_data[gi*SCALAR_REG_WIDTH +: SCALAR_REG_WIDTH];
        end
    endgenerate

    // Returns {hit, index}: lowest match at or above start, else lowest match overall (wrap).
    function automatic logic [RR_W:0] rr_pick(input logic [NUM_REQ-1:0] match,
                                              input logic [RR_W-1:0]    start);
        logic [RR_W-1:0] any_idx;
        logic [RR_W-1:0] up_idx;
        logic            any_hit;
        logic            up_hit;
        any_idx = '0;
        up_idx  = '0;
        any_hit = 1'b0;
        up_hit  = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (match[i]) begin
                any_idx = RR_W'(i);
                any_hit = 1'b1;
                if (RR_W'(i) >= start) begin
                    up_idx = RR_W'(i);
                    up_hit = 1'b1;
                end
            end
        end
        return {any_hit, (up_hit ? up_idx : any_idx)};
    endfunction

    always_comb begin
        int_pick    = rr_pick(int_match, rr_int_reg);
        fp_pick     = rr_pick(fp_match, rr_fp_reg);
        int_idx     = int_pick[RR_W-1:0];
        fp_idx      = fp_pick[RR_W-1:0];
        int_grant   = int_pick[RR_W] && !flush;
        fp_grant    = fp_pick[RR_W] && !flush;
        rr_int_next = (int_idx == RR_W'(NUM_REQ - 1)) ? '0 : int_idx + RR_W'(1);
        rr_fp_next  = (fp_idx == RR_W'(NUM_REQ - 1)) ? '0 : fp_idx + RR_W'(1);
        req_ready   = '0;
        if (int_grant) req_ready[int_idx] = 1'b1;
        if (fp_grant)  req_ready[fp_idx]  = 1'b1;
    end

`ifdef SCALAR_ARB_X0_ZERO_EN
    // x0 stays hard-wired to zero: the grant still completes, the write is dropped.
    assign int_wr_en = int_grant && (ptr_arr[int_idx] != '0);
`else
    assign int_wr_en = int_grant;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_int_reg   <= '0;
            rr_fp_reg    <= '0;
            write_reg    <= 1'b0;
            wr_ptr_reg   <= '0;
            wr_data_reg  <= '0;
            fwrite_reg   <= 1'b0;
            fwr_ptr_reg  <= '0;
            fwr_data_reg <= '0;
        end else begin
            write_reg  <= int_wr_en;
            fwrite_reg <= fp_grant;
            if (int_grant) begin
                rr_int_reg  <= rr_int_next;
                wr_ptr_reg  <= ptr_arr[int_idx];
                wr_data_reg <= data_arr[int_idx];
            end
            if (fp_grant) begin
                rr_fp_reg    <= rr_fp_next;
                fwr_ptr_reg  <= ptr_arr[fp_idx];
                fwr_data_reg <= data_arr[fp_idx];
            end
        end
    end

    assign write          = write_reg;
    assign wr_access_ptr  = wr_ptr_reg;
    assign write_data     = wr_data_reg;
    assign fwrite         = fwrite_reg;
    assign wr_faccess_ptr = fwr_ptr_reg;
    assign fwrite_data    = fwr_data_reg;

endmodule
